mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have the following ports (one clock; reset synchronous, active-high):
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-high (1 = reset)
- m0_req  in  1  requester 0 request; held until m0_gnt
- m0_we  in  1  requester 0 write (1) / read (0)
- m0_be  in  4  requester 0 byte enables; bit i covers wdata[8i+7:8i]
- m0_addr  in  32  requester 0 byte address; bits [1:0] ignored
- m0_wdata  in  32  requester 0 write data
- m0_gnt  out  1  one-cycle pulse: request accepted
- m0_rvalid  out  1  one-cycle pulse: transaction complete
- m0_rdata  out  32  read data, valid with m0_rvalid
- m1_req, m1_we, m1_be, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  (same as m0, for requester 1)
- ram_en  out  1  RAM data-port enable
- ram_wr  out  1  RAM full-word write
- ram_addr  out  32  RAM byte address, always word-aligned
- ram_wdata  out  32  RAM write data
- ram_data  in  32  RAM read data; registered, valid 1 cycle after ram_en with ram_wr=0

Function
REQ-002 SHALL implement states IDLE, RESP, MERGE.
REQ-003 In IDLE, when at least one mN_req=1, SHALL grant exactly one requester, assert its mN_gnt for that cycle only, and drive ram_en=1 with ram_addr={mN_addr[31:2],2'b00}.
REQ-004 Arbitration SHALL be round-robin: with both requesting, grant the requester not granted last; the priority pointer is updated on every grant.
REQ-005 Read (we=0): ram_wr=0 in the grant cycle; next state RESP.
REQ-006 Full write (be=4'b1111) or empty write (be=4'b0000): ram_wr=1 only for be=1111, ram_wdata=mN_wdata; next state RESP.
REQ-007 Partial write (be neither 0000 nor 1111): grant cycle issues a read (ram_wr=0) and captures the winner's be and wdata; next state MERGE.
REQ-008 MERGE (1 cycle): ram_en=1, ram_wr=1, same ram_addr; ram_wdata byte i = wdata byte i if be[i]=1, else ram_data byte i; next state RESP.
REQ-009 RESP (1 cycle): mN_rvalid=1 for the granted requester only; mN_rdata=ram_data for reads, 32'h0 for writes; ram_en=0; next state IDLE; no grant issued in RESP.
REQ-010 Latency: read/full/empty write gnt at T, rvalid at T+1; partial write gnt at T, rvalid at T+2; at most one transaction in flight.
REQ-011 Outside REQ-003..REQ-009, all outputs SHALL be 0; mN_rdata=0 whenever mN_rvalid=0.
REQ-012 Requests and changes to the request fields arriving while not in IDLE SHALL be ignored until the next IDLE cycle.

Reset
REQ-013 With rst_n=1 at a clock edge: state=IDLE, priority pointer favours m0, captured be/wdata cleared, all outputs 0 from the following cycle.
REQ-014 Reset in MERGE or RESP SHALL abandon the transaction: no rvalid and no further RAM write are issued.

Configuration
REQ-015 Macro MEM_ARB_RMW_EN: when defined, partial writes follow REQ-007/REQ-008. When undefined, the MERGE state is not built, be is ignored, and every write is a full-word write per REQ-006 with ram_wr=1.

Verification
REQ-016 Read: m0 reads 0x10, RAM holds 0xDEADBEEF -> m0_gnt at T, ram_en=1/ram_wr=0/ram_addr=0x10 at T, m0_rvalid=1 with m0_rdata=0xDEADBEEF at T+1.
REQ-017 Contention: m0 and m1 request continuously from reset -> grant order m0, m1, m0, m1; grants 2 cycles apart.
REQ-018 RMW (macro defined): RAM[0x20]=0x11223344; m1 writes be=0101, wdata=0xAABBCCDD -> ram_wr=1 with ram_wdata=0x11BB33DD at T+1; m1_rvalid=1 with m1_rdata=0 at T+2.
REQ-019 Same stimulus as REQ-018 with the macro undefined -> ram_wr=1 with ram_wdata=0xAABBCCDD at T; m1_rvalid at T+1.
REQ-020 Empty write be=0000 -> ram_wr stays 0; m0_rvalid=1 at T+1.
REQ-021 Reset in MERGE -> no ram_wr and no rvalid afterwards; next m0 request is granted first.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port word RAM.
// Define MEM_ARB_RMW_EN to merge partial-byte writes by read-modify-write.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        ram_en,
    output logic        ram_wr,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_data
);

`ifdef MEM_ARB_RMW_EN
    typedef enum logic [1:0] {IDLE, RESP, MERGE} state_t;
`else
    typedef enum logic [1:0] {IDLE, RESP} state_t;
`endif

    state_t      state_reg, state_next;
    logic        prio_reg, prio_next;   // 1 = m1 wins a tie
    logic        sel_reg, sel_next;     // requester owning the transaction
    logic        rd_reg, rd_next;
    logic [29:0] addr_reg, addr_next;

    logic        win;
    logic        win_we;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;
    logic [3:0]  win_be;

    assign win       = (m0_req && m1_req) ? prio_reg : m1_req;
    assign win_we    = win ? m1_we    : m0_we;
    assign win_addr  = win ? m1_addr  : m0_addr;
    assign win_wdata = win ? m1_wdata : m0_wdata;
    assign win_be    = win ? m1_be    : m0_be;

`ifdef MEM_ARB_RMW_EN
    logic [3:0]  be_reg, be_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [31:0] merged;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            assign merged[8*gi +: 8] = be_reg[gi] ? wdata_reg[8*gi +: 8] : ram_data[8*gi +: 8];
        end
    endgenerate

    logic unused_bits;
    assign unused_bits = ^{m0_addr[1:0], m1_addr[1:0]};
`else
    // Byte enables have no effect when every write is a full-word write.
    logic unused_bits;
    assign unused_bits = ^{m0_addr[1:0], m1_addr[1:0], win_be};
`endif

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_reg <= IDLE;
            prio_reg  <= 1'b0;
            sel_reg   <= 1'b0;
            rd_reg    <= 1'b0;
            addr_reg  <= '0;
`ifdef MEM_ARB_RMW_EN
            be_reg    <= '0;
            wdata_reg <= '0;
`endif
        end else begin
            state_reg <= state_next;
            prio_reg  <= prio_next;
            sel_reg   <= sel_next;
            rd_reg    <= rd_next;
            addr_reg  <= addr_next;
`ifdef MEM_ARB_RMW_EN
            be_reg    <= be_next;
            wdata_reg <= wdata_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        prio_next  = prio_reg;
        sel_next   = sel_reg;
        rd_next    = rd_reg;
        addr_next  = addr_reg;
`ifdef MEM_ARB_RMW_EN
        be_next    = be_reg;
        wdata_next = wdata_reg;
`endif
        m0_gnt     = 1'b0;
        m1_gnt     = 1'b0;
        m0_rvalid  = 1'b0;
        m1_rvalid  = 1'b0;
        m0_rdata   = '0;
        m1_rdata   = '0;
        ram_en     = 1'b0;
        ram_wr     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;

        case (state_reg)
            IDLE: begin
                if (m0_req || m1_req) begin
                    m0_gnt     = ~win;
                    m1_gnt     = win;
                    sel_next   = win;
                    prio_next  = ~win;
                    rd_next    = ~win_we;
                    addr_next  = win_addr[31:2];
                    ram_en     = 1'b1;
                    ram_addr   = {win_addr[31:2], 2'b00};
                    state_next = RESP;
                    if (win_we) begin
`ifdef MEM_ARB_RMW_EN
                        if (win_be == 4'b1111 || win_be == 4'b0000) begin
                            ram_wr    = (win_be == 4'b1111);
                            ram_wdata = win_wdata;
                        end else begin
                            // Read the old word now; the merge is written next cycle.
                            be_next    = win_be;
                            wdata_next = win_wdata;
                            state_next = MERGE;
                        end
`else
                        ram_wr    = 1'b1;
                        ram_wdata = win_wdata;
`endif
                    end
                end
            end
`ifdef MEM_ARB_RMW_EN
            MERGE: begin
                ram_en     = 1'b1;
                ram_wr     = 1'b1;
                ram_addr   = {addr_reg, 2'b00};
                ram_wdata  = merged;
                state_next = RESP;
            end
`endif
            RESP: begin
                m0_rvalid  = ~sel_reg;
                m1_rvalid  = sel_reg;
                m0_rdata   = (!sel_reg && rd_reg) ? ram_data : 32'h0;
                m1_rdata   = (sel_reg && rd_reg) ? ram_data : 32'h0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // A reset cycle abandons whatever is in flight: nothing leaves the block.
        if (rst_n) begin
            m0_gnt    = 1'b0;
            m1_gnt    = 1'b0;
            m0_rvalid = 1'b0;
            m1_rvalid = 1'b0;
            m0_rdata  = '0;
            m1_rdata  = '0;
            ram_en    = 1'b0;
            ram_wr    = 1'b0;
            ram_addr  = '0;
            ram_wdata = '0;
        end
    end

endmodule
